pifo_sram_radix: RTL and testbench



---
 rtl/pifo_sram_radix.sv | 247 ++++++++++++++++++++++++
 tb/tb_pifo_sram_radix.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_sram_radix.sv
`timescale 1ns/1ps
// SRAM-backed PIFO tree node with RADIX child slots per word. Pushes balance on
// subtree count, pops take the minimum priority, and child commands are combinational.
module pifo_sram_radix #(
  parameter int PTW   = 16,
  parameter int MTW   = 32,
  parameter int CTW   = 10,
  parameter int ADW   = 20,
  parameter int RADIX = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_push,
  input  logic [MTW+PTW-1:0]              i_push_data,
  input  logic                            i_pop,
  output logic [MTW+PTW-1:0]              o_pop_data,
  output logic                            o_pop_valid,
  output logic                            o_ready,
  output logic                            o_push,
  output logic [MTW+PTW-1:0]              o_push_data,
  output logic                            o_pop,
  input  logic [MTW+PTW-1:0]              i_pop_data,
  output logic [ADW-1:0]                  o_child_addr,
  output logic                            o_read,
  output logic [ADW-1:0]                  o_read_addr,
  input  logic [RADIX*(CTW+MTW+PTW)-1:0]  i_read_data,
  output logic                            o_write,
  output logic [ADW-1:0]                  o_write_addr,
  output logic [RADIX*(CTW+MTW+PTW)-1:0]  o_write_data,
  input  logic [ADW-1:0]                  i_my_addr,
  output logic                            o_overflow
);

  localparam int EW = CTW + MTW + PTW;
  localparam int DW = MTW + PTW;
  localparam int WW = RADIX * EW;
  localparam int SW = $clog2(RADIX);
  localparam logic [DW-1:0] EMPTY_E = {{MTW{1'b0}}, {PTW{1'b1}}};

  typedef enum logic [2:0] {IDLE, PUSH, POP, PP, WB} state_t;

  function automatic logic [CTW-1:0] cnt_of(input logic [WW-1:0] wd, input logic [SW-1:0] k);
    return wd[int'(k)*EW+DW +: CTW];
  endfunction

  function automatic logic [PTW-1:0] prio_of(input logic [WW-1:0] wd, input logic [SW-1:0] k);
    return wd[int'(k)*EW +: PTW];
  endfunction

  function automatic logic [DW-1:0] ent_of(input logic [WW-1:0] wd, input logic [SW-1:0] k);
    return wd[int'(k)*EW +: DW];
  endfunction

  function automatic logic [WW-1:0] set_slot(input logic [WW-1:0] wd, input logic [SW-1:0] k,
                                             input logic [CTW-1:0] c, input logic [DW-1:0] e);
    logic [WW-1:0] r;
    r = wd;
    r[int'(k)*EW +: EW] = {c, e};
    return r;
  endfunction

  // Strict less-than keeps the lowest index on ties.
  function automatic logic [SW-1:0] cmin_f(input logic [WW-1:0] wd);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 1; k < RADIX; k++)
      if (cnt_of(wd, SW'(k)) < cnt_of(wd, s)) s = SW'(k);
    return s;
  endfunction

  function automatic logic [SW-1:0] pmin_f(input logic [WW-1:0] wd);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 1; k < RADIX; k++)
      if (prio_of(wd, SW'(k)) < prio_of(wd, s)) s = SW'(k);
    return s;
  endfunction

  function automatic logic empty_f(input logic [WW-1:0] wd);
    logic e;
    e = 1'b1;
    for (int k = 0; k < RADIX; k++)
      if (prio_of(wd, SW'(k)) != {PTW{1'b1}}) e = 1'b0;
    return e;
  endfunction

  state_t          state, state_nxt;
  logic [DW-1:0]   lat_data_p0;
  logic [ADW-1:0]  lat_addr_p0;
  logic            byp_vld_p1;
  logic [WW-1:0]   byp_word_p1;
  logic [WW-1:0]   wb_word_p1;
  logic [SW-1:0]   wb_slot_p1;
  logic            wb_en_p1, wb_child_p1, wb_dec_p1;
  logic            wb_en_nxt, wb_child_nxt, wb_dec_nxt;

  logic [WW-1:0]   w;
  logic [SW-1:0]   cs, ps;
  logic            node_empty, accept;
  logic [CTW-1:0]  cs_cnt, ps_cnt, wb_cnt;
  logic [PTW-1:0]  cs_prio, ps_prio, lat_prio;
  logic [ADW-1:0]  child_base;

  // Stage 1: node word from SRAM or from the same-cycle write bypass
  assign w          = byp_vld_p1 ? byp_word_p1 : i_read_data;
  assign cs         = cmin_f(w);
  assign ps         = pmin_f(w);
  assign node_empty = empty_f(w);
  assign cs_cnt     = cnt_of(w, cs);
  assign ps_cnt     = cnt_of(w, ps);
  assign cs_prio    = prio_of(w, cs);
  assign ps_prio    = prio_of(w, ps);
  assign lat_prio   = lat_data_p0[PTW-1:0];
  assign wb_cnt     = cnt_of(wb_word_p1, wb_slot_p1);
  assign child_base = lat_addr_p0 * ADW'(RADIX);

  assign o_ready      = (state == IDLE) || (state == PUSH) || (state == WB);
  assign accept       = o_ready && (i_push || i_pop) && !i_rst;
  assign o_read_addr  = i_my_addr;
  assign o_write_addr = lat_addr_p0;

  always_comb begin
    state_nxt    = state;
    o_read       = accept;
    o_pop_data   = '1;
    o_pop_valid  = 1'b0;
    o_push       = 1'b0;
    o_push_data  = '0;
    o_pop        = 1'b0;
    o_child_addr = '1;
    o_write      = 1'b0;
    o_write_data = '0;
    o_overflow   = 1'b0;
    wb_en_nxt    = 1'b0;
    wb_child_nxt = 1'b0;
    wb_dec_nxt   = 1'b0;

    case (state)
      PUSH: begin
        o_child_addr = child_base + ADW'(cs);
        if (cs_cnt == {CTW{1'b1}}) begin
          o_overflow = 1'b1;
        end else begin
          o_write = 1'b1;
          if (cs_prio == {PTW{1'b1}}) begin
            o_write_data = set_slot(w, cs, cs_cnt + CTW'(1), lat_data_p0);
          end else if (lat_prio < cs_prio) begin
            o_write_data = set_slot(w, cs, cs_cnt + CTW'(1), lat_data_p0);
            o_push       = 1'b1;
            o_push_data  = ent_of(w, cs);
          end else begin
            o_write_data = set_slot(w, cs, cs_cnt + CTW'(1), ent_of(w, cs));
            o_push       = 1'b1;
            o_push_data  = lat_data_p0;
          end
        end
      end
      POP: begin
        o_child_addr = child_base + ADW'(ps);
        if (!node_empty) begin
          o_pop_data   = ent_of(w, ps);
          o_pop_valid  = 1'b1;
          o_pop        = ps_cnt > CTW'(1);
          wb_en_nxt    = 1'b1;
          wb_child_nxt = ps_cnt > CTW'(1);
          wb_dec_nxt   = 1'b1;
        end
      end
      PP: begin
        o_child_addr = child_base + ADW'(ps);
        o_pop_valid  = 1'b1;
        if (node_empty || lat_prio <= ps_prio) begin
          o_pop_data = lat_data_p0;
        end else begin
          o_pop_data = ent_of(w, ps);
          if (ps_cnt == CTW'(1)) begin
            o_write      = 1'b1;
            o_write_data = set_slot(w, ps, ps_cnt, lat_data_p0);
          end else begin
            o_push       = 1'b1;
            o_pop        = 1'b1;
            o_push_data  = lat_data_p0;
            wb_en_nxt    = 1'b1;
            wb_child_nxt = 1'b1;
          end
        end
      end
      WB: begin
        if (wb_en_p1) begin
          o_write      = 1'b1;
          o_write_data = set_slot(wb_word_p1, wb_slot_p1,
                                  wb_dec_p1 ? wb_cnt - CTW'(1) : wb_cnt,
                                  wb_child_p1 ? i_pop_data : EMPTY_E);
        end
      end
      default: ;
    endcase

    if (accept)
      state_nxt = (i_push && i_pop) ? PP : (i_push ? PUSH : POP);
    else if (state == POP || state == PP)
      state_nxt = WB;
    else
      state_nxt = IDLE;

    // A reset cycle aborts whatever was in flight.
    if (i_rst) begin
      o_write     = 1'b0;
      o_push      = 1'b0;
      o_pop       = 1'b0;
      o_pop_valid = 1'b0;
      o_overflow  = 1'b0;
    end
  end

  // Stage 2: command latch, bypass record and pending write-back
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      lat_data_p0 <= '0;
      lat_addr_p0 <= '0;
      byp_vld_p1  <= 1'b0;
      byp_word_p1 <= '0;
      wb_word_p1  <= '0;
      wb_slot_p1  <= '0;
      wb_en_p1    <= 1'b0;
      wb_child_p1 <= 1'b0;
      wb_dec_p1   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_data_p0 <= i_push_data;
        lat_addr_p0 <= i_my_addr;
      end
      byp_vld_p1  <= o_write && o_read && (o_write_addr == i_my_addr);
      byp_word_p1 <= o_write_data;
      if (state == POP || state == PP) begin
        wb_word_p1  <= w;
        wb_slot_p1  <= ps;
        wb_en_p1    <= wb_en_nxt;
        wb_child_p1 <= wb_child_nxt;
        wb_dec_p1   <= wb_dec_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pifo_sram_radix.sv
`timescale 1ns/1ps
// Directed bench for pifo_sram_radix: small SRAM model, hand-built node words,
// expected values written out per step.
module tb_pifo_sram_radix;

  localparam int PTW = 16, MTW = 32, CTW = 2, ADW = 20, RADIX = 4;
  localparam int EW = CTW + MTW + PTW;
  localparam int DW = MTW + PTW;
  localparam int WW = RADIX * EW;
  localparam logic [DW-1:0] EMPTY_E = {32'h0, 16'hFFFF};
  localparam logic [WW-1:0] EMPTY_W = {RADIX{{2'b00, EMPTY_E}}};

  logic clk, rst, push, pop;
  logic [DW-1:0]  push_data, child_pop_data;
  logic [ADW-1:0] my_addr;
  logic [DW-1:0]  o_pop_data, o_push_data;
  logic           o_pop_valid, o_ready, o_push, o_pop, o_read, o_write, o_overflow;
  logic [ADW-1:0] o_child_addr, o_read_addr, o_write_addr;
  logic [WW-1:0]  o_write_data, rdata;

  logic [WW-1:0]  mem [16];
  logic           tb_we;
  logic [3:0]     tb_wa;
  logic [WW-1:0]  tb_wd;

  int n_chk = 0;
  int n_fail = 0;

  pifo_sram_radix #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .RADIX(RADIX)) dut (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_push_data(push_data), .i_pop(pop),
    .o_pop_data(o_pop_data), .o_pop_valid(o_pop_valid), .o_ready(o_ready),
    .o_push(o_push), .o_push_data(o_push_data), .o_pop(o_pop), .i_pop_data(child_pop_data),
    .o_child_addr(o_child_addr), .o_read(o_read), .o_read_addr(o_read_addr),
    .i_read_data(rdata), .o_write(o_write), .o_write_addr(o_write_addr),
    .o_write_data(o_write_data), .i_my_addr(my_addr), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with one-cycle read latency; a same-cycle read returns the old word.
  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (o_write) mem[o_write_addr[3:0]] <= o_write_data;
    if (o_read) rdata <= mem[o_read_addr[3:0]];
  end

  function automatic logic [DW-1:0] ent(input logic [31:0] m, input logic [15:0] p);
    return {m, p};
  endfunction

  function automatic logic [WW-1:0] put(input logic [WW-1:0] wd, input int k,
                                        input logic [CTW-1:0] c, input logic [DW-1:0] e);
    logic [WW-1:0] r;
    r = wd;
    r[k*EW +: EW] = {c, e};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic pu, input logic po, input logic [DW-1:0] d, input logic [ADW-1:0] a);
    push = pu;
    pop = po;
    push_data = d;
    my_addr = a;
  endtask

  task automatic load(input int a, input logic [WW-1:0] wd);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = 4'(a);
    tb_wd = wd;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  logic [WW-1:0] w1, w2, f1, d1, p3, p4, p5;

  initial begin
    rst = 1'b1;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    child_pop_data = '0;
    cmd(1'b0, 1'b0, '0, '0);
    for (int a = 0; a < 16; a++) load(a, EMPTY_W);

    // Reset state; a command during reset must not read
    @(negedge clk);
    push = 1'b1;
    #1;
    chk("rst_read_gated", o_read, 0);
    chk("rst_pop_data", o_pop_data, {DW{1'b1}});
    chk("rst_child_addr", o_child_addr, {ADW{1'b1}});
    chk("rst_write_data", o_write_data, 0);
    chk("rst_ctrl", {o_write, o_push, o_pop, o_pop_valid, o_overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Push 5, push 3 back-to-back on addr 0, then pop
    w1 = put(EMPTY_W, 0, 2'd1, ent(32'hA5, 16'd5));
    w2 = put(w1, 1, 2'd1, ent(32'hA3, 16'd3));
    cmd(1'b1, 1'b0, ent(32'hA5, 16'd5), 20'd0);
    #1;
    chk("acc_read", {o_ready, o_read}, 2'b11);
    @(negedge clk);
    cmd(1'b1, 1'b0, ent(32'hA3, 16'd3), 20'd0);
    #1;
    chk("push5_ctrl", {o_write, o_push, o_overflow}, 3'b100);
    chk("push5_word", o_write_data, w1);
    @(negedge clk);
    cmd(1'b0, 1'b1, '0, 20'd0);
    #1;
    chk("push3_bypass_word", o_write_data, w2);
    chk("push3_no_child", o_push, 0);
    @(negedge clk);
    cmd(1'b0, 1'b0, '0, 20'd0);
    #1;
    chk("pop_data", o_pop_data, ent(32'hA3, 16'd3));
    chk("pop_ctrl", {o_pop_valid, o_pop, o_write, o_ready}, 4'b1000);
    @(negedge clk);
    #1;
    chk("pop_wb_word", o_write_data, w1);
    chk("pop_wb_write", o_write, 1);
    @(negedge clk);
    chk("mem0_after_pop", mem[0], w1);

    // Displacement push on addr 1, then a push that goes down to the child
    f1 = EMPTY_W;
    for (int k = 0; k < RADIX; k++) f1 = put(f1, k, 2'd1, ent(32'h10 + k, 16'd10));
    d1 = put(f1, 0, 2'd2, ent(32'h44, 16'd4));
    load(1, f1);
    cmd(1'b1, 1'b0, ent(32'h44, 16'd4), 20'd1);
    @(negedge clk);
    cmd(1'b1, 1'b0, ent(32'h66, 16'd15), 20'd1);
    #1;
    chk("disp_word", o_write_data, d1);
    chk("disp_push", {o_push, o_overflow, o_write}, 3'b101);
    chk("disp_push_data", o_push_data, ent(32'h10, 16'd10));
    chk("disp_child_addr", o_child_addr, 20'd4);
    @(negedge clk);
    cmd(1'b0, 1'b0, '0, 20'd1);
    #1;
    chk("down_word", o_write_data, put(d1, 1, 2'd2, ent(32'h11, 16'd10)));
    chk("down_push_data", o_push_data, ent(32'h66, 16'd15));
    chk("down_child_addr", o_child_addr, 20'd5);

    // Push-pop returning the incoming entry, then push-pop replacing a count-1 slot
    p3 = put(put(put(EMPTY_W, 0, 2'd1, ent(32'h90, 16'd9)), 1, 2'd1, ent(32'h70, 16'd7)),
             2, 2'd1, ent(32'h12, 16'd12));
    load(2, p3);
    cmd(1'b1, 1'b1, ent(32'h22, 16'd2), 20'd2);
    @(negedge clk);
    cmd(1'b0, 1'b0, '0, 20'd2);
    #1;
    chk("pp_bypass_data", o_pop_data, ent(32'h22, 16'd2));
    chk("pp_bypass_ctrl", {o_pop_valid, o_write, o_push, o_pop}, 4'b1000);
    @(negedge clk);
    cmd(1'b1, 1'b1, ent(32'h88, 16'd8), 20'd2);
    #1;
    chk("pp_bypass_wb", o_write, 0);
    @(negedge clk);
    cmd(1'b0, 1'b0, '0, 20'd2);
    #1;
    chk("pp_c1_data", o_pop_data, ent(32'h70, 16'd7));
    chk("pp_c1_ctrl", {o_write, o_push, o_pop}, 3'b100);
    chk("pp_c1_word", o_write_data, put(p3, 1, 2'd1, ent(32'h88, 16'd8)));
    @(negedge clk);
    #1;
    chk("pp_c1_wb", o_write, 0);

    // Push-pop replacing a slot with a subtree
    p4 = put(put(put(EMPTY_W, 0, 2'd1, ent(32'h30, 16'd30)), 1, 2'd3, ent(32'h77, 16'd7)),
             3, 2'd2, ent(32'h25, 16'd25));
    load(3, p4);
    child_pop_data = ent(32'hC0, 16'd8);
    cmd(1'b1, 1'b1, ent(32'h20, 16'd20), 20'd3);
    @(negedge clk);
    cmd(1'b0, 1'b0, '0, 20'd3);
    #1;
    chk("pp_rep_data", o_pop_data, ent(32'h77, 16'd7));
    chk("pp_rep_ctrl", {o_pop_valid, o_push, o_pop, o_write}, 4'b1110);
    chk("pp_rep_push_data", o_push_data, ent(32'h20, 16'd20));
    chk("pp_rep_child_addr", o_child_addr, 20'd13);
    @(negedge clk);
    #1;
    chk("pp_rep_wb_word", o_write_data, put(p4, 1, 2'd3, ent(32'hC0, 16'd8)));
    chk("pp_rep_wb_addr", {o_write, o_write_addr}, {1'b1, 20'd3});

    // Overflow on a node whose counts are all saturated
    p5 = EMPTY_W;
    for (int k = 0; k < RADIX; k++) p5 = put(p5, k, 2'd3, ent(32'h50 + k, 16'd10));
    load(4, p5);
    cmd(1'b1, 1'b0, ent(32'h55, 16'd1), 20'd4);
    @(negedge clk);
    cmd(1'b0, 1'b0, '0, 20'd4);
    #1;
    chk("ovf_ctrl", {o_overflow, o_write, o_push}, 3'b100);
    @(negedge clk);
    #1;
    chk("ovf_one_cycle", o_overflow, 0);
    chk("ovf_mem", mem[4], p5);

    // Pop on an empty node
    cmd(1'b0, 1'b1, '0, 20'd5);
    @(negedge clk);
    cmd(1'b0, 1'b0, '0, 20'd5);
    #1;
    chk("empty_pop_ctrl", {o_pop_valid, o_pop}, 2'b00);
    chk("empty_pop_data", o_pop_data, {DW{1'b1}});
    @(negedge clk);
    cmd(1'b1, 1'b0, ent(32'h99, 16'd9), 20'd6);
    #1;
    chk("empty_pop_wb", o_write, 0);

    // Reset asserted while a push is in its write cycle
    @(negedge clk);
    rst = 1'b1;
    cmd(1'b0, 1'b0, '0, 20'd6);
    #1;
    chk("rst_mid_push", {o_write, o_read, o_push}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_pop_data", o_pop_data, {DW{1'b1}});
    chk("post_rst_child_addr", o_child_addr, {ADW{1'b1}});
    chk("post_rst_write_data", o_write_data, 0);
    chk("post_rst_ctrl", {o_ready, o_write, o_push, o_pop, o_pop_valid, o_overflow}, 6'b100000);
    chk("post_rst_mem", mem[6], EMPTY_W);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
